// File: rtl/timer_dev_pkg.sv
// Register map, control-field layout, mode codes and FSM encoding for timer_dev.
// Shared with the system bridge so both sides decode the window identically.
package timer_dev_pkg;

  typedef enum logic [1:0] {
    OFF_CTRL   = 2'd0,
    OFF_PRESET = 2'd1,
    OFF_COUNT  = 2'd2,
    OFF_RSVD   = 2'd3
  } reg_off_e;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_RSVD2   = 2'd2,
    MODE_RSVD3   = 2'd3
  } mode_e;

  // Packed MSB-first: bit 3 IM, bits 2:1 MODE, bit 0 EN.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lane_en);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (lane_en[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a level interrupt.
// Registers live in a 16-byte window at BASE_ADDR; reads are combinational.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d, ctrl_wr;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;

  logic        sel, wr_any, wr_ctrl, wr_preset;
  reg_off_e    offset;
  logic        unused_addr_lsbs;

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = reg_off_e'(addr[3:2]);
  assign wr_any    = sel && (byteen != 4'b0000);
  assign wr_ctrl   = wr_any && (offset == OFF_CTRL);
  assign wr_preset = wr_any && (offset == OFF_PRESET);
  assign ctrl_wr   = byteen[0] ? ctrl_t'(wdata[3:0]) : ctrl_q;

  assign unused_addr_lsbs = ^addr[1:0];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;

    case (state_q)
      ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q == 32'd0) begin
          state_d   = ST_INT;
          pending_d = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (ctrl_q.mode == MODE_RELOAD) begin
          state_d   = ST_LOAD;
          pending_d = 1'b0;
        end else begin
          state_d   = ST_IDLE;
          ctrl_d.en = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Software writes are applied last so they override anything the FSM decided.
    if (wr_ctrl) begin
      ctrl_d    = ctrl_wr;
      pending_d = 1'b0;
      if (!ctrl_wr.en) begin
        state_d = ST_IDLE;
        count_d = count_q;
      end
    end
    if (wr_preset) begin
      preset_d  = merge_lanes(preset_q, wdata, byteen);
      pending_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        OFF_CTRL:   rdata = {28'd0, ctrl_q};
        OFF_PRESET: rdata = preset_q;
        OFF_COUNT:  rdata = count_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = pending_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios with fixed expectations,
// then randomized bus traffic compared against a behavioural model every cycle.
module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  timer_dev #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .byteen(byteen),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase names follow the requirement text.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;
  int          m_ph;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_ctrl = 4'h0; m_preset = 32'h0; m_count = 32'h0; m_pend = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0:    return {28'h0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_irq();
    return m_pend & m_ctrl[3];
  endfunction

  // One clock: drive the bus, predict the next model state, take the edge, compare.
  task automatic tick(input string tag, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
    int          nph;
    logic [3:0]  nctrl;
    logic [31:0] npre, ncnt;
    bit          npend, hit;
    nph = m_ph; nctrl = m_ctrl; npre = m_preset; ncnt = m_count; npend = m_pend;
    hit = (a[31:4] == BASE[31:4]) && (be != 4'b0);
    addr = a; byteen = be; wdata = wd;

    if (m_ph == PH_IDLE) begin
      if (m_ctrl[0]) nph = PH_LOAD;
    end else if (m_ph == PH_LOAD) begin
      ncnt = m_preset;
      nph  = PH_CNT;
    end else if (m_ph == PH_CNT) begin
      if (!m_ctrl[0]) nph = PH_IDLE;
      else if (m_count == 0) begin nph = PH_INT; npend = 1'b1; end
      else ncnt = m_count - 1;
    end else begin
      if (m_ctrl[2:1] == 2'd1) begin nph = PH_LOAD; npend = 1'b0; end
      else begin nph = PH_IDLE; nctrl[0] = 1'b0; end
    end

    if (hit && a[3:2] == 2'd0) begin
      nctrl = be[0] ? wd[3:0] : m_ctrl;
      npend = 1'b0;
      if (!nctrl[0]) begin nph = PH_IDLE; ncnt = m_count; end
    end
    if (hit && a[3:2] == 2'd1) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) npre[8*k +: 8] = wd[8*k +: 8];
      npend = 1'b0;
    end

    @(posedge clk);
    m_ph = nph; m_ctrl = nctrl; m_preset = npre; m_count = ncnt; m_pend = npend;
    #1;
    check({tag, ".irq"}, {31'h0, irq}, {31'h0, m_irq()});
    check({tag, ".rdata"}, rdata, m_read(a));
  endtask

  task automatic wr(input string tag, input int off, input logic [31:0] d, input logic [3:0] be);
    tick(tag, BASE + 32'(off * 4), be, d);
  endtask

  task automatic idle(input string tag, input int off);
    tick(tag, BASE + 32'(off * 4), 4'b0000, 32'h0);
  endtask

  // Called at posedge+1: pulse reset between clock edges.
  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #2 reset = 1'b1;
  endtask

  int          cseq [6];
  logic [31:0] ra, rd;
  logic [3:0]  rb;
  int          roff, rsel;

  initial begin
    cseq = '{3, 2, 1, 0, 0, 0};
    reset = 1'b0; addr = BASE; byteen = 4'b0; wdata = 32'h0;
    model_reset();

    // Reset state: every offset reads 0, irq low.
    #2;
    for (int off = 0; off < 4; off++) begin
      addr = BASE + 32'(off * 4);
      #1 check("rst.rdata", rdata, 32'h0);
    end
    check("rst.irq", {31'h0, irq}, 32'h0);
    @(negedge clk) reset = 1'b1;

    // One-shot: irq high exactly 8 edges after the CTRL write, and stays high.
    wr("A.pre", 1, 32'd5, 4'hF);
    wr("A.ctrl", 0, 32'h9, 4'hF);
    for (int e = 1; e <= 11; e++) begin
      idle("A.run", 2);
      check("A.irq_time", {31'h0, irq}, (e >= 8) ? 32'h1 : 32'h0);
      if (e == 2) check("A.count_loaded", rdata, 32'd5);
    end
    idle("A.rd_ctrl", 0);
    check("A.ctrl_en_cleared", rdata, 32'h8);
    idle("A.rd_count", 2);
    check("A.count_zero", rdata, 32'h0);
    wr("A.pre_clr", 1, 32'd5, 4'hF);
    check("A.irq_cleared", {31'h0, irq}, 32'h0);

    // Auto-reload: one-cycle pulses every 6 edges, COUNT 3,2,1,0 repeating.
    do_reset();
    wr("B.pre", 1, 32'd3, 4'hF);
    wr("B.ctrl", 0, 32'hB, 4'hF);
    for (int e = 1; e <= 25; e++) begin
      idle("B.run", 2);
      check("B.irq_pulse", {31'h0, irq}, (e >= 6 && (e - 6) % 6 == 0) ? 32'h1 : 32'h0);
      if (e >= 2) check("B.count_seq", rdata, 32'(cseq[(e - 2) % 6]));
    end

    // Masked interrupt, then unmasking via a CTRL write must not expose stale PENDING.
    do_reset();
    wr("C.pre", 1, 32'd10, 4'hF);
    wr("C.ctrl", 0, 32'h1, 4'hF);
    for (int e = 1; e <= 16; e++) begin
      idle("C.run", 2);
      check("C.irq_masked", {31'h0, irq}, 32'h0);
    end
    check("C.count_done", rdata, 32'h0);
    wr("C.unmask", 0, 32'h8, 4'hF);
    check("C.irq_after_unmask", {31'h0, irq}, 32'h0);
    repeat (3) idle("C.hold", 0);
    check("C.irq_stays_low", {31'h0, irq}, 32'h0);

    // Stop mid-count; lane-wise PRESET write.
    do_reset();
    wr("D.pre", 1, 32'd10, 4'hF);
    wr("D.ctrl", 0, 32'h1, 4'hF);
    repeat (8) idle("D.run", 2);
    check("D.count4", rdata, 32'd4);
    wr("D.stop", 0, 32'h0, 4'hF);
    idle("D.after_stop", 2);
    check("D.count_held", rdata, 32'd4);
    repeat (3) idle("D.idle", 2);
    check("D.count_still", rdata, 32'd4);
    wr("D.pre_full", 1, 32'h1234_5678, 4'hF);
    wr("D.pre_lane", 1, 32'hAABB_CCFF, 4'b0001);
    idle("D.rd_pre", 1);
    check("D.pre_lane_merge", rdata, 32'h1234_56FF);
    wr("D.count_wr", 2, 32'hDEAD_BEEF, 4'hF);
    check("D.count_ro", rdata, 32'd4);

    // Asynchronous reset in the middle of a count.
    do_reset();
    wr("E.pre", 1, 32'd10, 4'hF);
    wr("E.ctrl", 0, 32'h9, 4'hF);
    repeat (5) idle("E.run", 2);
    check("E.count7", rdata, 32'd7);
    #3 reset = 1'b0;
    #1 check("E.async_count", rdata, 32'h0);
    check("E.async_irq", {31'h0, irq}, 32'h0);
    addr = BASE;
    #1 check("E.async_ctrl", rdata, 32'h0);
    addr = BASE + 32'h4;
    #1 check("E.async_pre", rdata, 32'h0);
    model_reset();
    reset = 1'b1;
    for (int e = 0; e < 20; e++) begin
      idle("E.post", 2);
      check("E.no_irq", {31'h0, irq}, 32'h0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rsel = $urandom_range(0, 99);
      roff = $urandom_range(0, 3);
      ra   = BASE + 32'(roff * 4);
      if (rsel < 60) begin
        tick("R.idle", ra, 4'b0000, $urandom);
      end else if (rsel < 65) begin
        ra = $urandom;
        if (ra[31:4] == BASE[31:4]) ra = ra ^ 32'h0000_0100;
        tick("R.unsel", ra, 4'($urandom_range(1, 15)), $urandom);
      end else begin
        rb = 4'($urandom_range(1, 15));
        rd = $urandom;
        if (roff == 0) begin
          rd[0] = ($urandom_range(0, 3) != 0);
        end else if (roff == 1 && $urandom_range(0, 9) != 0) begin
          rd = 32'($urandom_range(0, 9));
          rb = 4'hF;
        end
        tick("R.wr", ra, rb, rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
